// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, register-file write-through
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic [4:0]      id_ctrl,

  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,

  input  logic            flush,
  input  logic            ex_stall,

  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd,
  output logic [XLEN-1:0] idex_rs1_data,
  output logic [XLEN-1:0] idex_rs2_data,
  output logic [XLEN-1:0] idex_imm,
  output logic [3:0]      idex_alu_op,
  output logic [4:0]      idex_ctrl,

  output logic            id_stall,
  output logic [CNTW-1:0] bubble_count
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic            idex_valid_q,    idex_valid_d;
  logic [XLEN-1:0] idex_pc_q,       idex_pc_d;
  logic [4:0]      idex_rs1_q,      idex_rs1_d;
  logic [4:0]      idex_rs2_q,      idex_rs2_d;
  logic [4:0]      idex_rd_q,       idex_rd_d;
  logic [XLEN-1:0] idex_rs1_data_q, idex_rs1_data_d;
  logic [XLEN-1:0] idex_rs2_data_q, idex_rs2_data_d;
  logic [XLEN-1:0] idex_imm_q,      idex_imm_d;
  logic [3:0]      idex_alu_op_q,   idex_alu_op_d;
  logic [4:0]      idex_ctrl_q,     idex_ctrl_d;
  logic [CNTW-1:0] bubble_count_q,  bubble_count_d;

  logic            rs1_dep_s;
  logic            rs2_dep_s;
  logic            lu_s;
  logic            wt_rs1_s;
  logic            wt_rs2_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;
  act_e            act_s;

  // ctrl[1] is mem_read: a load in EX whose destination the decoded instruction reads
  assign rs1_dep_s = id_uses_rs1 & (id_rs1 == idex_rd_q);
  assign rs2_dep_s = id_uses_rs2 & (id_rs2 == idex_rd_q);
  assign lu_s      = id_valid & idex_valid_q & idex_ctrl_q[1] & (idex_rd_q != 5'd0)
                   & (rs1_dep_s | rs2_dep_s);

  assign id_stall  = ~flush & (ex_stall | lu_s);

  // Register file is written late in the cycle, so a same-cycle write must bypass the read
  assign wt_rs1_s   = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == id_rs1);
  assign wt_rs2_s   = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == id_rs2);
  assign rs1_data_s = wt_rs1_s ? wb_data : id_rs1_data;
  assign rs2_data_s = wt_rs2_s ? wb_data : id_rs2_data;

  always_comb begin
    if (flush) begin
      act_s = ACT_FLUSH;
    end else if (ex_stall) begin
      act_s = ACT_HOLD;
    end else if (lu_s) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  always_comb begin
    idex_valid_d    = idex_valid_q;
    idex_pc_d       = idex_pc_q;
    idex_rs1_d      = idex_rs1_q;
    idex_rs2_d      = idex_rs2_q;
    idex_rd_d       = idex_rd_q;
    idex_rs1_data_d = idex_rs1_data_q;
    idex_rs2_data_d = idex_rs2_data_q;
    idex_imm_d      = idex_imm_q;
    idex_alu_op_d   = idex_alu_op_q;
    idex_ctrl_d     = idex_ctrl_q;
    bubble_count_d  = bubble_count_q;
    case (act_s)
      ACT_FLUSH: begin
        idex_valid_d = 1'b0;
        idex_ctrl_d  = 5'd0;
      end
      ACT_HOLD: begin
        idex_valid_d = idex_valid_q;
      end
      ACT_BUBBLE: begin
        idex_valid_d = 1'b0;
        idex_ctrl_d  = 5'd0;
        if (bubble_count_q != CNT_MAX) begin
          bubble_count_d = bubble_count_q + CNT_ONE;
        end else begin
          bubble_count_d = bubble_count_q;
        end
      end
      ACT_LOAD: begin
        idex_valid_d    = id_valid;
        idex_pc_d       = id_pc;
        idex_rs1_d      = id_rs1;
        idex_rs2_d      = id_rs2;
        idex_rd_d       = id_rd;
        idex_rs1_data_d = rs1_data_s;
        idex_rs2_data_d = rs2_data_s;
        idex_imm_d      = id_imm;
        idex_alu_op_d   = id_alu_op;
        idex_ctrl_d     = id_ctrl;
      end
      default: begin
        idex_valid_d = 1'b0;
        idex_ctrl_d  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid_q    <= 1'b0;
      idex_pc_q       <= {XLEN{1'b0}};
      idex_rs1_q      <= 5'd0;
      idex_rs2_q      <= 5'd0;
      idex_rd_q       <= 5'd0;
      idex_rs1_data_q <= {XLEN{1'b0}};
      idex_rs2_data_q <= {XLEN{1'b0}};
      idex_imm_q      <= {XLEN{1'b0}};
      idex_alu_op_q   <= 4'd0;
      idex_ctrl_q     <= 5'd0;
      bubble_count_q  <= {CNTW{1'b0}};
    end else begin
      idex_valid_q    <= idex_valid_d;
      idex_pc_q       <= idex_pc_d;
      idex_rs1_q      <= idex_rs1_d;
      idex_rs2_q      <= idex_rs2_d;
      idex_rd_q       <= idex_rd_d;
      idex_rs1_data_q <= idex_rs1_data_d;
      idex_rs2_data_q <= idex_rs2_data_d;
      idex_imm_q      <= idex_imm_d;
      idex_alu_op_q   <= idex_alu_op_d;
      idex_ctrl_q     <= idex_ctrl_d;
      bubble_count_q  <= bubble_count_d;
    end
  end

  assign idex_valid    = idex_valid_q;
  assign idex_pc       = idex_pc_q;
  assign idex_rs1      = idex_rs1_q;
  assign idex_rs2      = idex_rs2_q;
  assign idex_rd       = idex_rd_q;
  assign idex_rs1_data = idex_rs1_data_q;
  assign idex_rs2_data = idex_rs2_data_q;
  assign idex_imm      = idex_imm_q;
  assign idex_alu_op   = idex_alu_op_q;
  assign idex_ctrl     = idex_ctrl_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of per-cycle stimulus with hand-computed
// results, plus sequences for asynchronous reset mid-hazard and counter saturation.
module tb_id_ex_stage;

  localparam logic [4:0] LD  = 5'h1B;
  localparam logic [4:0] ADD = 5'h08;
  localparam logic [4:0] NOC = 5'h00;

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [63:0] d1, d2;
    logic [4:0]  ctrl;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [63:0] wbd;
    logic        fl, exs;
    logic        e_stall, e_valid;
    logic [63:0] e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [63:0] e_d1, e_d2;
    logic [4:0]  e_ctrl;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, wb_reg_write, flush, ex_stall;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_ctrl, wb_rd;
  logic [3:0]  id_alu_op;

  logic        idex_valid, id_stall;
  logic [63:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd, idex_ctrl;
  logic [3:0]  idex_alu_op;
  logic [15:0] bubble_count;

  logic        s_valid, s_stall;
  logic [63:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd, s_ctrl;
  logic [3:0]  s_alu_op;
  logic [1:0]  s_count;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [22];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(64), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .ex_stall(ex_stall), .idex_valid(idex_valid),
    .idex_pc(idex_pc), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm),
    .idex_alu_op(idex_alu_op), .idex_ctrl(idex_ctrl), .id_stall(id_stall),
    .bubble_count(bubble_count)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation
  id_ex_stage #(.XLEN(64), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .ex_stall(ex_stall), .idex_valid(s_valid),
    .idex_pc(s_pc), .idex_rs1(s_rs1), .idex_rs2(s_rs2), .idex_rd(s_rd),
    .idex_rs1_data(s_rs1_data), .idex_rs2_data(s_rs2_data), .idex_imm(s_imm),
    .idex_alu_op(s_alu_op), .idex_ctrl(s_ctrl), .id_stall(s_stall),
    .bubble_count(s_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // imm and alu_op are derived from pc so their expected values follow e_pc
  task automatic drive(input vec_t v);
    id_valid     = v.valid;
    id_pc        = v.pc;
    id_rs1       = v.rs1;
    id_rs2       = v.rs2;
    id_rd        = v.rd;
    id_uses_rs1  = v.u1;
    id_uses_rs2  = v.u2;
    id_rs1_data  = v.d1;
    id_rs2_data  = v.d2;
    id_imm       = v.pc ^ 64'hF0;
    id_alu_op    = v.pc[5:2];
    id_ctrl      = v.ctrl;
    wb_reg_write = v.wbw;
    wb_rd        = v.wbrd;
    wb_data      = v.wbd;
    flush        = v.fl;
    ex_stall     = v.exs;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [63:0] ep;
    ep = v.e_pc;
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d id_stall", k), {63'd0, id_stall}, {63'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d valid", k), {63'd0, idex_valid}, {63'd0, v.e_valid});
    chk($sformatf("v%0d pc", k), idex_pc, ep);
    chk($sformatf("v%0d imm", k), idex_imm, ep ^ 64'hF0);
    chk($sformatf("v%0d alu_op", k), {60'd0, idex_alu_op}, {60'd0, ep[5:2]});
    chk($sformatf("v%0d rs1", k), {59'd0, idex_rs1}, {59'd0, v.e_rs1});
    chk($sformatf("v%0d rs2", k), {59'd0, idex_rs2}, {59'd0, v.e_rs2});
    chk($sformatf("v%0d rd", k), {59'd0, idex_rd}, {59'd0, v.e_rd});
    chk($sformatf("v%0d rs1_data", k), idex_rs1_data, v.e_d1);
    chk($sformatf("v%0d rs2_data", k), idex_rs2_data, v.e_d2);
    chk($sformatf("v%0d ctrl", k), {59'd0, idex_ctrl}, {59'd0, v.e_ctrl});
    chk($sformatf("v%0d count", k), {48'd0, bubble_count}, {48'd0, v.e_cnt});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, {63'd0, idex_valid}, 64'd0);
    chk({nm, " pc"}, idex_pc, 64'd0);
    chk({nm, " rd"}, {59'd0, idex_rd}, 64'd0);
    chk({nm, " rs1_data"}, idex_rs1_data, 64'd0);
    chk({nm, " rs2_data"}, idex_rs2_data, 64'd0);
    chk({nm, " imm"}, idex_imm, 64'd0);
    chk({nm, " ctrl"}, {59'd0, idex_ctrl}, 64'd0);
    chk({nm, " count"}, {48'd0, bubble_count}, 64'd0);
    chk({nm, " sat count"}, {62'd0, s_count}, 64'd0);
    chk({nm, " id_stall"}, {63'd0, id_stall}, 64'd0);
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  vec_t ldv, depv;

  initial begin
    //                valid pc       rs1   rs2   rd     u1    u2    d1          d2          ctrl wbw   wbrd  wbd           fl    exs | stall valid e_pc     e_rs1 e_rs2 e_rd   e_d1        e_d2          e_ctrl e_cnt
    vecs[0]  = '{1'b1, 64'h100,  5'd1, 5'd2, 5'd5,  1'b1, 1'b1, 64'h11,     64'h22,     LD,  1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h100,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       LD,  16'd0};
    vecs[1]  = '{1'b1, 64'h104,  5'd5, 5'd6, 5'd7,  1'b1, 1'b1, 64'h55,     64'h66,     ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b1, 1'b0, 64'h100,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       NOC, 16'd1};
    vecs[2]  = '{1'b1, 64'h104,  5'd5, 5'd6, 5'd7,  1'b1, 1'b1, 64'h55,     64'h66,     ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h104,  5'd5, 5'd6, 5'd7,  64'h55,     64'h66,       ADD, 16'd1};
    vecs[3]  = '{1'b1, 64'h108,  5'd3, 5'd7, 5'd8,  1'b1, 1'b1, 64'h44,     64'h1,      ADD, 1'b1, 5'd7, 64'hDEAD,     1'b0, 1'b0, 1'b0, 1'b1, 64'h108,  5'd3, 5'd7, 5'd8,  64'h44,     64'hDEAD,     ADD, 16'd1};
    vecs[4]  = '{1'b1, 64'h10C,  5'd0, 5'd0, 5'd9,  1'b1, 1'b1, 64'h2,      64'h1,      ADD, 1'b1, 5'd0, 64'hDEAD,     1'b0, 1'b0, 1'b0, 1'b1, 64'h10C,  5'd0, 5'd0, 5'd9,  64'h2,      64'h1,        ADD, 16'd1};
    vecs[5]  = '{1'b1, 64'h110,  5'd7, 5'd4, 5'd0,  1'b1, 1'b1, 64'h9,      64'hA,      LD,  1'b1, 5'd7, 64'hBEEF,     1'b0, 1'b0, 1'b0, 1'b1, 64'h110,  5'd7, 5'd4, 5'd0,  64'hBEEF,   64'hA,        LD,  16'd1};
    vecs[6]  = '{1'b1, 64'h114,  5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 64'h0,      64'h0,      ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h114,  5'd0, 5'd0, 5'd10, 64'h0,      64'h0,        ADD, 16'd1};
    vecs[7]  = '{1'b1, 64'h118,  5'd1, 5'd2, 5'd5,  1'b1, 1'b1, 64'h11,     64'h22,     LD,  1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h118,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       LD,  16'd1};
    vecs[8]  = '{1'b1, 64'h11C,  5'd3, 5'd5, 5'd6,  1'b1, 1'b1, 64'h33,     64'h55,     ADD, 1'b0, 5'd0, 64'h0,        1'b1, 1'b0, 1'b0, 1'b0, 64'h118,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       NOC, 16'd1};
    vecs[9]  = '{1'b1, 64'h120,  5'd1, 5'd2, 5'd5,  1'b1, 1'b1, 64'h11,     64'h22,     LD,  1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h120,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       LD,  16'd1};
    vecs[10] = '{1'b0, 64'h124,  5'd5, 5'd5, 5'd6,  1'b1, 1'b1, 64'h77,     64'h88,     ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b0, 64'h124,  5'd5, 5'd5, 5'd6,  64'h77,     64'h88,       ADD, 16'd1};
    vecs[11] = '{1'b1, 64'h128,  5'd1, 5'd2, 5'd5,  1'b1, 1'b1, 64'h11,     64'h22,     LD,  1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h128,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       LD,  16'd1};
    vecs[12] = '{1'b1, 64'h12C,  5'd5, 5'd5, 5'd6,  1'b0, 1'b0, 64'h77,     64'h88,     ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h12C,  5'd5, 5'd5, 5'd6,  64'h77,     64'h88,       ADD, 16'd1};
    vecs[13] = '{1'b1, 64'h1000, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 64'h3,      64'h4,      ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h1000, 5'd1, 5'd2, 5'd11, 64'h3,      64'h4,        ADD, 16'd1};
    vecs[14] = '{1'b1, 64'h2000, 5'd5, 5'd6, 5'd12, 1'b1, 1'b1, 64'h99,     64'h99,     LD,  1'b0, 5'd0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h1000, 5'd1, 5'd2, 5'd11, 64'h3,      64'h4,        ADD, 16'd1};
    vecs[15] = vecs[14];
    vecs[16] = vecs[14];
    vecs[17] = '{1'b1, 64'h2000, 5'd5, 5'd6, 5'd12, 1'b1, 1'b1, 64'h99,     64'h99,     LD,  1'b0, 5'd0, 64'h0,        1'b1, 1'b1, 1'b0, 1'b0, 64'h1000, 5'd1, 5'd2, 5'd11, 64'h3,      64'h4,        NOC, 16'd1};
    vecs[18] = '{1'b1, 64'h130,  5'd1, 5'd2, 5'd5,  1'b1, 1'b1, 64'h11,     64'h22,     LD,  1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h130,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       LD,  16'd1};
    vecs[19] = '{1'b1, 64'h134,  5'd3, 5'd5, 5'd6,  1'b1, 1'b1, 64'h33,     64'h55,     ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h130,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       LD,  16'd1};
    vecs[20] = '{1'b1, 64'h134,  5'd3, 5'd5, 5'd6,  1'b1, 1'b1, 64'h33,     64'h55,     ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b1, 1'b0, 64'h130,  5'd1, 5'd2, 5'd5,  64'h11,     64'h22,       NOC, 16'd2};
    vecs[21] = '{1'b1, 64'h134,  5'd3, 5'd5, 5'd6,  1'b1, 1'b1, 64'h33,     64'h55,     ADD, 1'b0, 5'd0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1, 64'h134,  5'd3, 5'd5, 5'd6,  64'h33,     64'h55,       ADD, 16'd2};

    ldv  = vecs[0];
    depv = vecs[1];

    // Reset held across a clock edge: outputs stay zero regardless of inputs
    rst = 1'b1;
    drive(vecs[0]);
    #3;
    chk_zero("reset");
    @(posedge clk);
    #1;
    chk_zero("reset after edge");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 22; k++) begin
      run_vec(k, vecs[k]);
    end

    // Asynchronous reset between edges while a load-use stall is pending
    ldv.pc = 64'h140;
    step(ldv);
    @(negedge clk);
    depv.pc = 64'h144;
    drive(depv);
    #1;
    chk("async id_stall before rst", {63'd0, id_stall}, 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("async reset");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset valid", {63'd0, idex_valid}, 64'd1);
    chk("post-reset pc", idex_pc, 64'h144);
    chk("post-reset rd", {59'd0, idex_rd}, 64'd7);
    chk("post-reset ctrl", {59'd0, idex_ctrl}, {59'd0, ADD});
    chk("post-reset count", {48'd0, bubble_count}, 64'd0);

    // Four load-use hazards: the 2-bit counter must stop at 3
    for (int i = 0; i < 4; i++) begin
      ldv.pc  = 64'h300 + 64'(i * 16);
      depv.pc = 64'h304 + 64'(i * 16);
      step(ldv);
      step(depv);
      chk($sformatf("sat bubble %0d valid", i), {63'd0, idex_valid}, 64'd0);
      chk($sformatf("sat wide count %0d", i), {48'd0, bubble_count}, 64'(i + 1));
      chk($sformatf("sat narrow count %0d", i), {62'd0, s_count}, (i < 3) ? 64'(i + 1) : 64'd3);
      step(depv);
      chk($sformatf("sat dep load %0d pc", i), idex_pc, depv.pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width of PC, register data and immediate.
REQ-002 Parameter CNTW, default 16, width of the load-use bubble counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_valid  input  1  decode slot holds a real instruction.
REQ-006 id_pc  input  XLEN  decoded instruction PC.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  decoded register indices.
REQ-008 id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-009 id_rs1_data, id_rs2_data  input  XLEN each  register-file read data.
REQ-010 id_imm  input  XLEN  sign-extended immediate.
REQ-011 id_alu_op  input  4  ALU operation code, carried unmodified.
REQ-012 id_ctrl  input  5  {mem_to_reg, reg_write, mem_write, mem_read, alu_src}.
REQ-013 wb_reg_write, wb_rd, wb_data  input  1/5/XLEN  write-back port writing the register file this cycle.
REQ-014 flush  input  1  branch/jump redirect from EX; kill the decode slot.
REQ-015 ex_stall  input  1  downstream hold; ID/EX must not advance.
REQ-016 idex_valid, idex_pc, idex_rs1, idex_rs2, idex_rd, idex_rs1_data, idex_rs2_data, idex_imm, idex_alu_op, idex_ctrl  output  widths as inputs  registered ID/EX contents; idex_rs1/idex_rs2/idex_rd drive the forwarding unit.
REQ-017 id_stall  output  1  combinational; holds PC and IF/ID when high.
REQ-018 bubble_count  output  CNTW  saturating count of load-use bubbles inserted.

Function
REQ-019 Load-use hazard (lu) SHALL be: id_valid & idex_valid & idex_ctrl[1] (mem_read) & idex_rd!=0 & ((id_uses_rs1 & id_rs1==idex_rd) | (id_uses_rs2 & id_rs2==idex_rd)).
REQ-020 id_stall SHALL equal !flush & (ex_stall | lu).
REQ-021 Each edge SHALL take exactly one action, priority flush > ex_stall > lu > load.
REQ-022 flush: next state is a bubble, even if ex_stall or lu is high.
REQ-023 ex_stall (no flush): all ID/EX registers hold; bubble_count unchanged.
REQ-024 lu (no flush, no ex_stall): next state is a bubble; bubble_count increments.
REQ-025 load: all idex_* fields capture the id_* inputs; idex_valid <= id_valid.
REQ-026 Bubble SHALL clear idex_valid and idex_ctrl to 0; other idex_* fields retain previous values.
REQ-027 Write-through: on load, if wb_reg_write & wb_rd!=0 & wb_rd==id_rs1, idex_rs1_data SHALL capture wb_data instead of id_rs1_data; same rule independently for rs2.
REQ-028 Write-through SHALL never apply for index 0; x0 operand captures id_rsN_data as given.
REQ-029 Latency: decode to idex_* exactly one cycle when not stalled, bubbled or flushed.
REQ-030 bubble_count SHALL saturate at 2^CNTW-1 and not wrap.
REQ-031 Invalid decode slot (id_valid=0) SHALL never raise lu.
REQ-032 Load followed by dependent instruction SHALL cost exactly one bubble; the dependent instruction enters ID/EX on the following edge, where the forwarding unit supplies the loaded value from MEM/WB.

Reset
REQ-033 While rst is high, all idex_* outputs and bubble_count SHALL be 0, independent of clk.
REQ-034 rst asserted mid-stall SHALL abandon the stall; after release the first edge performs a normal load.
REQ-035 id_stall SHALL read 0 during reset, since idex_valid=0 forces lu=0.

Verification
REQ-036 ld x5 in ID/EX (mem_read=1, rd=5), ID add uses rs1=5 -> id_stall=1, next edge idex_valid=0, idex_ctrl=0, bubble_count=1; following edge the add loads.
REQ-037 Same as REQ-036 with flush=1 -> id_stall=0, next edge bubble, bubble_count stays 0.
REQ-038 ex_stall=1 for 3 cycles with idex_pc=0x1000 -> idex_pc stays 0x1000, id_stall=1, counter unchanged.
REQ-039 wb_reg_write=1, wb_rd=7, wb_data=0xDEAD, id_rs2=7, id_rs2_data=0x1 -> idex_rs2_data=0xDEAD; repeat with rd=0 -> 0x1 captured.
REQ-040 Load with idex_rd=0 and ID rs1=0 -> no stall; CNTW=2 with 4 hazards -> bubble_count=3.
REQ-041 rst pulsed asynchronously between edges during lu -> outputs 0 immediately; first post-reset edge loads ID contents.
